// File: rtl/easy_axi_rd_mst.sv
// AXI read-traffic master: issues a run of INCR bursts with several reads in flight,
// checks each returned burst's beat count and response, and reports progress and errors.
//   state   | meaning
//   S_IDLE  | waiting for start; busy=0
//   S_RUN   | issuing AR requests; arvalid limited by issue count and outstanding
//   S_DRAIN | all AR issued; waiting for the last rlast
module easy_axi_rd_mst #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int MAX_OUTSTD = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_num_trans,
  input  logic              rready_en,
  output logic              axi_mst_arvalid,
  input  logic              axi_mst_arready,
  output logic [ID_W-1:0]   axi_mst_arid,
  output logic [ADDR_W-1:0] axi_mst_araddr,
  output logic [LEN_W-1:0]  axi_mst_arlen,
  output logic [2:0]        axi_mst_arsize,
  output logic [1:0]        axi_mst_arburst,
  input  logic              axi_mst_rvalid,
  output logic              axi_mst_rready,
  input  logic [DATA_W-1:0] axi_mst_rdata,
  input  logic [1:0]        axi_mst_rresp,
  input  logic              axi_mst_rlast,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  trans_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              proto_err,
  output logic [DATA_W-1:0] last_rdata
);

  localparam int              OW      = $clog2(MAX_OUTSTD + 1);
  localparam logic [2:0]      AR_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [OW-1:0]   MAX_O   = OW'(MAX_OUTSTD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]  arlen_q, arlen_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [OW-1:0]     outstd_q, outstd_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  trans_cnt_q, trans_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic [DATA_W-1:0] last_rdata_q, last_rdata_d;

  logic              ar_hs, r_hs, r_sol, r_done;
  logic [ADDR_W-1:0] ar_step;

  always_comb begin
    ar_hs   = arvalid_q & axi_mst_arready;
    r_hs    = axi_mst_rvalid & rready_en;
    r_sol   = r_hs & (outstd_q != '0);
    r_done  = r_sol & axi_mst_rlast;
    ar_step = (ADDR_W'(len_q) + ADDR_W'(1)) << AR_SIZE;

    state_d      = state_q;
    arvalid_d    = arvalid_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    len_d        = len_q;
    num_d        = num_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    trans_cnt_d  = trans_cnt_q;
    err_cnt_d    = err_cnt_q;
    proto_err_d  = proto_err_q;
    last_rdata_d = last_rdata_q;
    beat_d       = beat_q;
    issued_d     = issued_q + CNT_W'(ar_hs);
    outstd_d     = outstd_q + OW'(ar_hs) - OW'(r_done);

    // A beat with nothing outstanding is flagged and otherwise dropped.
    if (r_hs && outstd_q == '0) proto_err_d = 1'b1;
    if (r_sol) begin
      last_rdata_d = axi_mst_rdata;
      if (axi_mst_rresp != 2'b00 && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (axi_mst_rlast) begin
        if (beat_q != len_q) proto_err_d = 1'b1;
        beat_d      = '0;
        trans_cnt_d = trans_cnt_q + CNT_W'(1);
      end else begin
        if (beat_q == len_q) proto_err_d = 1'b1;
        beat_d = beat_q + LEN_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = cfg_len;
          num_d       = cfg_num_trans;
          araddr_d    = cfg_base_addr;
          arlen_d     = cfg_len;
          arid_d      = '0;
          issued_d    = '0;
          beat_d      = '0;
          trans_cnt_d = '0;
          err_cnt_d   = '0;
          proto_err_d = 1'b0;
          if (cfg_num_trans == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = S_RUN;
            busy_d    = 1'b1;
            arvalid_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ar_hs) begin
          araddr_d = araddr_q + ar_step;
          arid_d   = arid_q + ID_W'(1);
        end
        // An un-accepted request is always held, so the payload stays stable.
        arvalid_d = (arvalid_q && !axi_mst_arready) ||
                    ((issued_d < num_q) && (outstd_d < MAX_O));
        if (issued_d == num_q) begin
          state_d   = S_DRAIN;
          arvalid_d = 1'b0;
        end
      end
      S_DRAIN: begin
        arvalid_d = 1'b0;
        if (outstd_d == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      arvalid_q    <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      len_q        <= '0;
      num_q        <= '0;
      issued_q     <= '0;
      outstd_q     <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trans_cnt_q  <= '0;
      err_cnt_q    <= '0;
      proto_err_q  <= 1'b0;
      last_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      len_q        <= len_d;
      num_q        <= num_d;
      issued_q     <= issued_d;
      outstd_q     <= outstd_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trans_cnt_q  <= trans_cnt_d;
      err_cnt_q    <= err_cnt_d;
      proto_err_q  <= proto_err_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  assign axi_mst_arvalid = arvalid_q;
  assign axi_mst_arid    = arid_q;
  assign axi_mst_araddr  = araddr_q;
  assign axi_mst_arlen   = arlen_q;
  assign axi_mst_arsize  = AR_SIZE;
  assign axi_mst_arburst = 2'b01;
  assign axi_mst_rready  = rready_en;
  assign busy            = busy_q;
  assign done            = done_q;
  assign trans_cnt       = trans_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign proto_err       = proto_err_q;
  assign last_rdata      = last_rdata_q;

endmodule
